// File: rtl/fetch_loader_ctrl.sv
// Fetch-side loader: decodes serial command bytes, writes little-endian instruction words
// into instruction memory, and gates the pipeline with halt / pipeline-reset.
module fetch_loader_ctrl #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_rx_valid,
    input  logic [7:0]         i_rx_data,
    input  logic               i_prog_end,
    output logic               o_we,
    output logic [NB_ADDR-1:0] o_load_addr,
    output logic [NB_DATA-1:0] o_instr_data,
    output logic               o_halt,
    output logic               o_pipe_rst_n,
    output logic               o_load_done,
    output logic               o_cmd_err,
    output logic [2:0]         o_state
);

    localparam int unsigned CNT_W = ((NB_ADDR > 8) ? NB_ADDR : 8) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(1) << NB_ADDR;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_HALT = 8'h48;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LD_COUNT = 3'd1,
        S_LD_BYTES = 3'd2,
        S_LD_WRITE = 3'd3,
        S_RUN      = 3'd4,
        S_STEP     = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [31:0]        word_q, word_d;
    logic               pend_q, pend_d;
    logic               we_q, we_d;
    logic [NB_ADDR-1:0] load_addr_q, load_addr_d;
    logic [NB_DATA-1:0] instr_q, instr_d;
    logic               halt_q, halt_d;
    logic               pipe_rst_n_q, pipe_rst_n_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               cmd_valid;
    logic [7:0]         cmd_byte;

    // State and output registers
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            pend_q       <= 1'b0;
            we_q         <= 1'b0;
            load_addr_q  <= '0;
            instr_q      <= '0;
            halt_q       <= 1'b1;
            pipe_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            pend_q       <= pend_d;
            we_q         <= we_d;
            load_addr_q  <= load_addr_d;
            instr_q      <= instr_d;
            halt_q       <= halt_d;
            pipe_rst_n_q <= pipe_rst_n_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        pend_d      = pend_q;
        load_addr_d = load_addr_q;
        instr_d     = instr_q;
        err_d       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_byte    = 8'h00;

        case (state_q)
            S_IDLE: begin
                // A byte caught during the final write is decoded here first
                cmd_valid = pend_q | i_rx_valid;
                cmd_byte  = pend_q ? word_q[7:0] : i_rx_data;
                pend_d    = 1'b0;
                if (cmd_valid) begin
                    case (cmd_byte)
                        CMD_LOAD: state_d = S_LD_COUNT;
                        CMD_RUN:  state_d = S_RUN;
                        CMD_STEP: state_d = S_STEP;
                        CMD_HALT: state_d = S_IDLE;
                        default:  err_d   = 1'b1;
                    endcase
                end
            end
            S_LD_COUNT: begin
                if (i_rx_valid) begin
                    rem_d      = (i_rx_data == 8'h00) ? FULL_CNT : CNT_W'(i_rx_data);
                    addr_d     = '0;
                    byte_cnt_d = 2'd0;
                    state_d    = S_LD_BYTES;
                end
            end
            S_LD_BYTES: begin
                if (i_rx_valid) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = i_rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        load_addr_d = addr_q;
                        instr_d     = NB_DATA'({i_rx_data, word_q[23:0]});
                        state_d     = S_LD_WRITE;
                    end
                end
            end
            S_LD_WRITE: begin
                addr_d = addr_q + NB_ADDR'(1);
                rem_d  = rem_q - CNT_W'(1);
                if (i_rx_valid) begin
                    word_d[7:0] = i_rx_data;
                    byte_cnt_d  = 2'd1;
                    pend_d      = (rem_q == CNT_W'(1));
                end
                state_d = (rem_q == CNT_W'(1)) ? S_IDLE : S_LD_BYTES;
            end
            S_RUN: begin
                if (i_prog_end || (i_rx_valid && (i_rx_data == CMD_HALT))) begin
                    state_d = S_IDLE;
                end
            end
            S_STEP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        we_d         = (state_d == S_LD_WRITE);
        halt_d       = !((state_d == S_RUN) || (state_d == S_STEP));
        pipe_rst_n_d = !((state_d == S_LD_COUNT) || (state_d == S_LD_BYTES) ||
                         (state_d == S_LD_WRITE));
        done_d       = (state_q == S_LD_WRITE) && (state_d == S_IDLE);
    end

    assign o_we         = we_q;
    assign o_load_addr  = load_addr_q;
    assign o_instr_data = instr_q;
    assign o_halt       = halt_q;
    assign o_pipe_rst_n = pipe_rst_n_q;
    assign o_load_done  = done_q;
    assign o_cmd_err    = err_q;
    assign o_state      = 3'(state_q);

endmodule

// File: doc/fetch_loader_ctrl.md
FETCH_LOADER_CTRL -- requirements
Module: fetch_loader_ctrl

Interface
REQ-001 SHALL have parameter NB_DATA, default 32: instruction word width.
REQ-002 SHALL have parameter NB_ADDR, default 8: instruction memory address width (2^NB_ADDR words).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_rx_valid  input  1  one-cycle strobe: i_rx_data holds a new command/data byte.
REQ-006 SHALL have port i_rx_data  input  8  received byte.
REQ-007 SHALL have port i_prog_end  input  1  pipeline reports end-of-program (HALT instruction retired).
REQ-008 SHALL have port o_we  output  1  instruction memory write enable.
REQ-009 SHALL have port o_load_addr  output  NB_ADDR  instruction memory write address.
REQ-010 SHALL have port o_instr_data  output  NB_DATA  instruction word to write.
REQ-011 SHALL have port o_halt  output  1  freeze pipeline/PC (drives fetch i_halt).
REQ-012 SHALL have port o_pipe_rst_n  output  1  active-low pipeline reset; held low while loading.
REQ-013 SHALL have port o_load_done  output  1  one-cycle pulse after last word written.
REQ-014 SHALL have port o_cmd_err  output  1  one-cycle pulse on unrecognised command byte.
REQ-015 SHALL have port o_state  output  3  current FSM state encoding, for debug.

Function
REQ-016 SHALL implement FSM states IDLE, LD_COUNT, LD_BYTES, LD_WRITE, RUN, STEP; all outputs registered.
REQ-017 IDLE: o_halt=1, o_pipe_rst_n=1; on i_rx_valid decode byte: 0x4C 'L' -> LD_COUNT; 0x52 'R' -> RUN; 0x53 'S' -> STEP; 0x48 'H' -> stay IDLE, no error; any other -> stay IDLE, pulse o_cmd_err next cycle.
REQ-018 LD_COUNT: next valid byte = word count N; N=0 means 2^NB_ADDR words; address counter cleared to 0; -> LD_BYTES.
REQ-019 LD_* states: o_halt=1, o_pipe_rst_n=0.
REQ-020 LD_BYTES: assemble word little-endian, first byte -> bits [7:0], fourth byte -> [31:24]; 2-bit byte counter; on fourth byte -> LD_WRITE.
REQ-021 LD_WRITE (exactly one cycle): o_we=1, o_load_addr=address counter, o_instr_data=assembled word; then address +1 mod 2^NB_ADDR, remaining count -1.
REQ-022 After LD_WRITE: remaining count nonzero -> LD_BYTES; zero -> IDLE with o_load_done=1 for one cycle.
REQ-023 A byte with i_rx_valid during LD_WRITE SHALL be captured as byte 0 of the next word (no byte loss); if that was the last word, it is decoded as a command in IDLE-entry cycle.
REQ-024 o_we SHALL be 0 in every state except LD_WRITE; o_load_addr/o_instr_data hold last values otherwise.
REQ-025 RUN: o_halt=0; -> IDLE on i_prog_end or 'H' byte; other bytes ignored, no o_cmd_err.
REQ-026 i_prog_end and 'H' in the same cycle SHALL cause a single transition to IDLE.
REQ-027 STEP: o_halt=0 for exactly one clock, then IDLE (o_halt=1); bytes during STEP ignored.
REQ-028 i_prog_end while IDLE or LD_* SHALL be ignored.
REQ-029 Command bytes are decoded in LD_COUNT/LD_BYTES as data, never as commands.

Reset
REQ-030 While i_rst_n=0 (asynchronously): state IDLE, o_halt=1, o_pipe_rst_n=0, o_we=0, o_load_addr=0, o_instr_data=0, o_load_done=0, o_cmd_err=0, counters 0.
REQ-031 First clock after i_rst_n release: o_pipe_rst_n=1, remain IDLE.
REQ-032 Reset asserted mid-load SHALL abort immediately; o_we low within the reset assertion, no partial write afterwards.

Verification
REQ-033 Load: 0x4C,0x02,0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE -> writes 0x12345678@0, 0xDEADBEEF@1, o_load_done one pulse, o_pipe_rst_n low throughout load.
REQ-034 Full load: 0x4C,0x00 then 1024 bytes -> 256 writes, addresses 0..255, no write after 255, single o_load_done.
REQ-035 Run: 'R' -> o_halt=0 next cycle; i_prog_end pulse -> o_halt=1 next cycle, state IDLE.
REQ-036 Step: 'S' -> o_halt=0 for exactly one cycle; repeat 3 times -> 3 one-cycle low windows.
REQ-037 Error/ignore: 0x7A in IDLE -> o_cmd_err pulse, state IDLE; 0x7A and 0x4C during RUN -> no error, stay RUN until 'H'.
REQ-038 Reset after 2 bytes of a word -> all outputs at reset values; after release, fresh 'L' load writes from address 0.
